// File: rtl/dma_desc_sched_pkg.sv
// Shared DMA types: descriptor/control/status structs, streamer handshake and FSM states.
`ifndef DMA_NUM_DESC
`define DMA_NUM_DESC 2
`endif

package dma_pkg;
   localparam int NUM_DESC     = `DMA_NUM_DESC;
   localparam int RD_TXN_DEPTH = 4;
   localparam int WR_TXN_DEPTH = 4;

   typedef logic [$clog2(NUM_DESC)-1:0]  idx_desc_t;
   // One extra bit so NUM_DESC itself is representable as the terminal count.
   typedef logic [$clog2(`DMA_NUM_DESC):0] desc_cnt_t;
   typedef logic [$clog2(RD_TXN_DEPTH):0] pend_rd_t;
   typedef logic [$clog2(WR_TXN_DEPTH):0] pend_wr_t;

   typedef enum logic [1:0] {
      DMA_ST_IDLE,
      DMA_ST_CFG,
      DMA_ST_RUN,
      DMA_ST_DONE
   } dma_st_t;

   typedef struct packed {
      logic        go;
      logic        abort_req;
      logic [7:0]  max_burst;
   } s_dma_control_t;

   typedef struct packed {
      logic [31:0] src_addr;
      logic [31:0] dst_addr;
      logic [31:0] num_bytes;
      logic        enable;
   } s_dma_desc_t;

   typedef struct packed {
      logic        valid;
      logic        rd_nwr;
   } s_dma_error_t;

   typedef struct packed {
      logic        error;
      logic        done;
   } s_dma_status_t;

   typedef struct packed {
      logic        valid;
      idx_desc_t   idx;
   } s_dma_str_in_t;

   typedef struct packed {
      logic        done;
   } s_dma_str_out_t;

   function automatic logic desc_live(input s_dma_desc_t d);
      return d.enable && (d.num_bytes != '0);
   endfunction
endpackage

// File: rtl/dma_desc_sched_pick.sv
// Combinational picker: lowest live descriptor at or above start, with a none-left indication.
module dma_desc_pick
   import dma_pkg::*;
(
   input  s_dma_desc_t [NUM_DESC-1:0] desc,
   input  desc_cnt_t                  start,
   output logic                       hit,
   output desc_cnt_t                  pick_idx
);
   // Walk downward so the lowest qualifying index is the last one written.
   always_comb begin
      hit      = 1'b0;
      pick_idx = desc_cnt_t'(NUM_DESC);
      for (int i = NUM_DESC-1; i >= 0; i--) begin
         if ((desc_cnt_t'(i) >= start) && desc_live(desc[i])) begin
            hit      = 1'b1;
            pick_idx = desc_cnt_t'(i);
         end
      end
   end

   logic unused_addr;
   always_comb begin
      unused_addr = 1'b0;
      for (int i = 0; i < NUM_DESC; i++)
         unused_addr = unused_addr ^ (^{desc[i].src_addr, desc[i].dst_addr});
   end
endmodule

// File: rtl/dma_desc_sched.sv
// DMA descriptor sequencer: walks CSR descriptors, hands each to rd/wr streamers,
// drains outstanding AXI traffic on abort/error and reports sticky done/error status.
module dma_desc_sched
   import dma_pkg::*;
(
   input  logic                       clk,
   input  logic                       rst,
   input  s_dma_control_t             dma_ctrl_i,
   input  s_dma_desc_t [NUM_DESC-1:0] dma_desc_i,
   input  s_dma_error_t               dma_error_i,
   input  pend_rd_t                   rd_pend_i,
   input  pend_wr_t                   wr_pend_i,
   output s_dma_str_in_t              dma_stream_rd_o,
   input  s_dma_str_out_t             dma_stream_rd_i,
   output s_dma_str_in_t              dma_stream_wr_o,
   input  s_dma_str_out_t             dma_stream_wr_i,
   output s_dma_status_t              dma_stats_o,
   output logic                       dma_active_o,
   output logic                       clear_dma_o
);
   dma_st_t   st;
   desc_cnt_t idx;
   logic      rd_vld, wr_vld;
   logic      rd_done_q, wr_done_q;
   logic      draining;
   logic      pick_hit;
   desc_cnt_t pick_idx;
   logic      rd_fin, wr_fin;

   dma_desc_pick u_pick (
      .desc     (dma_desc_i),
      .start    (idx),
      .hit      (pick_hit),
      .pick_idx (pick_idx)
   );

   // A done pulse only counts while that streamer is actually holding valid.
   assign rd_fin = rd_done_q | (rd_vld & dma_stream_rd_i.done);
   assign wr_fin = wr_done_q | (wr_vld & dma_stream_wr_i.done);

   assign dma_stream_rd_o.valid = rd_vld;
   assign dma_stream_rd_o.idx   = idx[$bits(idx_desc_t)-1:0];
   assign dma_stream_wr_o.valid = wr_vld;
   assign dma_stream_wr_o.idx   = idx[$bits(idx_desc_t)-1:0];

   always_ff @(posedge clk) begin
      if (!rst) begin
         st           <= DMA_ST_IDLE;
         idx          <= '0;
         rd_vld       <= 1'b0;
         wr_vld       <= 1'b0;
         rd_done_q    <= 1'b0;
         wr_done_q    <= 1'b0;
         draining     <= 1'b0;
         dma_stats_o  <= '0;
         dma_active_o <= 1'b0;
         clear_dma_o  <= 1'b0;
      end else begin
         clear_dma_o <= 1'b0;
         case (st)
            DMA_ST_IDLE: begin
               if (dma_ctrl_i.go) begin
                  st           <= DMA_ST_CFG;
                  clear_dma_o  <= 1'b1;
                  dma_stats_o  <= '0;
                  idx          <= '0;
                  dma_active_o <= 1'b1;
               end
            end
            DMA_ST_CFG, DMA_ST_RUN: begin
               if (dma_error_i.valid || dma_ctrl_i.abort_req) begin
                  // Error outranks abort and any coincident done pulse.
                  if (dma_error_i.valid) dma_stats_o.error <= 1'b1;
                  st        <= DMA_ST_RUN;
                  rd_vld    <= 1'b0;
                  wr_vld    <= 1'b0;
                  rd_done_q <= 1'b0;
                  wr_done_q <= 1'b0;
                  draining  <= 1'b1;
               end else if (draining) begin
                  if ((rd_pend_i == '0) && (wr_pend_i == '0)) begin
                     st               <= DMA_ST_DONE;
                     draining         <= 1'b0;
                     dma_stats_o.done <= 1'b1;
                     dma_active_o     <= 1'b0;
                  end
               end else if (st == DMA_ST_CFG) begin
                  if (pick_hit) begin
                     idx    <= pick_idx;
                     rd_vld <= 1'b1;
                     wr_vld <= 1'b1;
                     st     <= DMA_ST_RUN;
                  end else begin
                     st               <= DMA_ST_DONE;
                     dma_stats_o.done <= 1'b1;
                     dma_active_o     <= 1'b0;
                  end
               end else begin
                  if (rd_vld && dma_stream_rd_i.done) begin
                     rd_vld    <= 1'b0;
                     rd_done_q <= 1'b1;
                  end
                  if (wr_vld && dma_stream_wr_i.done) begin
                     wr_vld    <= 1'b0;
                     wr_done_q <= 1'b1;
                  end
                  if (rd_fin && wr_fin) begin
                     rd_done_q <= 1'b0;
                     wr_done_q <= 1'b0;
                     idx       <= idx + desc_cnt_t'(1);
                     st        <= DMA_ST_CFG;
                  end
               end
            end
            DMA_ST_DONE: begin
               // Requires go to drop first, so a held go never re-arms.
               if (!dma_ctrl_i.go) st <= DMA_ST_IDLE;
            end
            default: st <= DMA_ST_IDLE;
         endcase
      end
   end

   logic unused_ctrl;
   assign unused_ctrl = ^{dma_ctrl_i.max_burst, dma_error_i.rd_nwr};
endmodule

// File: tb/tb_dma_desc_sched.sv
// Directed bench for dma_desc_sched: normal walk, skip, abort drain, error, held go, reset.
module tb_dma_desc_sched;
   import dma_pkg::*;

   logic                       clk = 1'b0;
   logic                       rst = 1'b0;
   s_dma_control_t             ctrl;
   s_dma_desc_t [NUM_DESC-1:0] desc;
   s_dma_error_t               err;
   pend_rd_t                   rd_pend;
   pend_wr_t                   wr_pend;
   s_dma_str_in_t              str_rd, str_wr;
   s_dma_str_out_t             rd_done, wr_done;
   s_dma_status_t              stats;
   logic                       active, clear;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   dma_desc_sched dut (
      .clk             (clk),
      .rst             (rst),
      .dma_ctrl_i      (ctrl),
      .dma_desc_i      (desc),
      .dma_error_i     (err),
      .rd_pend_i       (rd_pend),
      .wr_pend_i       (wr_pend),
      .dma_stream_rd_o (str_rd),
      .dma_stream_rd_i (rd_done),
      .dma_stream_wr_o (str_wr),
      .dma_stream_wr_i (wr_done),
      .dma_stats_o     (stats),
      .dma_active_o    (active),
      .clear_dma_o     (clear)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_desc(input int i, input logic en, input logic [31:0] nb);
      desc[i].enable    = en;
      desc[i].num_bytes = nb;
      desc[i].src_addr  = 32'h1000 * (i + 1);
      desc[i].dst_addr  = 32'h8000 * (i + 1);
   endtask

   // Entered right after the edge that raised valid; pulses done at the given offsets.
   task automatic run_desc(input string tag, input int exp_idx, input int rd_dly, input int wr_dly);
      int last;
      chk({tag, "_vld"}, {str_rd.valid, str_wr.valid}, 2'b11);
      chk({tag, "_idx"}, {str_rd.idx, str_wr.idx}, {exp_idx[0], exp_idx[0]});
      last = (rd_dly > wr_dly) ? rd_dly : wr_dly;
      for (int c = 1; c <= last; c++) begin
         rd_done.done = (c == rd_dly);
         wr_done.done = (c == wr_dly);
         tick();
         chk({tag, "_hold"}, {clear, str_rd.valid, str_wr.valid},
             {1'b0, (c < rd_dly), (c < wr_dly)});
      end
      rd_done.done = 1'b0;
      wr_done.done = 1'b0;
   endtask

   task automatic start();
      ctrl.go = 1'b1;
      tick();
      chk("start_clear", {clear, active}, 2'b11);
      ctrl.go = 1'b0;
      tick();
   endtask

   initial begin
      #100000;
      $display("FAIL timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int rd_tab[5] = '{3, 2, 1, 1, 0};
      int wr_tab[5] = '{2, 2, 1, 0, 0};
      ctrl = '0; err = '0; rd_pend = '0; wr_pend = '0;
      rd_done = '0; wr_done = '0;
      set_desc(0, 1'b1, 32'd64);
      set_desc(1, 1'b1, 32'd64);

      // Reset state
      tick(); tick();
      chk("rst_str", {str_rd, str_wr}, '0);
      chk("rst_misc", {stats, active, clear}, 4'b0000);
      rst = 1'b1;

      // 1: both descriptors, rd done +10 / wr done +14
      start();
      run_desc("t1d0", 0, 10, 14);
      tick();
      run_desc("t1d1", 1, 10, 14);
      tick();
      chk("t1_stats", stats, 2'b01);
      chk("t1_active", {active, str_rd.valid, str_wr.valid}, 3'b000);
      err.valid = 1'b1;
      tick();
      err.valid = 1'b0;
      chk("t1_err_ignored", stats, 2'b01);
      tick();

      // 2: disabled + zero-length descriptors are skipped
      set_desc(0, 1'b0, 32'd64);
      set_desc(1, 1'b1, 32'd0);
      ctrl.go = 1'b1;
      tick();
      ctrl.go = 1'b0;
      n = 0;
      while (!stats.done && n < 4) begin
         chk("t2_novld", {str_rd.valid, str_wr.valid}, 2'b00);
         tick();
         n++;
      end
      chk("t2_done", {stats, str_rd.valid, str_wr.valid}, 4'b0100);
      chk("t2_within4", (n >= 1 && n <= 4), 1'b1);
      tick();

      // 3: abort mid desc0 with outstanding txns, drained over 5 cycles
      set_desc(0, 1'b1, 32'd64);
      set_desc(1, 1'b1, 32'd64);
      start();
      chk("t3_vld", {str_rd.valid, str_wr.valid}, 2'b11);
      rd_pend = 3; wr_pend = 2;
      ctrl.abort_req = 1'b1;
      tick();
      ctrl.abort_req = 1'b0;
      chk("t3_drop", {str_rd.valid, str_wr.valid, active}, 3'b001);
      for (int s = 0; s < 5; s++) begin
         rd_pend = pend_rd_t'(rd_tab[s]);
         wr_pend = pend_wr_t'(wr_tab[s]);
         rd_done.done = (s == 1);
         tick();
         rd_done.done = 1'b0;
         chk("t3_drain", {active, stats, str_rd.valid, str_wr.valid},
             (s < 4) ? 5'b10000 : 5'b00100);
      end
      tick();

      // 4: error with the final wr done pulse; desc1 never issued
      start();
      rd_done.done = 1'b1;
      tick();
      rd_done.done = 1'b0;
      tick();
      wr_done.done = 1'b1;
      err.valid    = 1'b1;
      tick();
      wr_done.done = 1'b0;
      err.valid    = 1'b0;
      chk("t4_err", {active, stats, str_rd.valid, str_wr.valid}, 5'b11000);
      tick();
      chk("t4_done", {active, stats}, 3'b011);
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("t4_noissue", {str_rd.valid, str_wr.valid, active}, 3'b000);
      end

      // 5: simultaneous done pulses, go held through DONE
      ctrl.go = 1'b1;
      tick();
      chk("t5_clear", {clear, stats}, 3'b100);
      tick();
      run_desc("t5d0", 0, 2, 2);
      tick();
      run_desc("t5d1", 1, 1, 1);
      tick();
      chk("t5_done", {stats, active}, 3'b010);
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("t5_norestart", {clear, active, stats}, 4'b0001);
      end
      ctrl.go = 1'b0;
      tick();
      ctrl.go = 1'b1;
      tick();
      chk("t5_restart", {clear, active, stats}, 4'b1100);
      ctrl.go = 1'b0;
      tick();
      chk("t5_run", {str_rd.valid, str_wr.valid}, 2'b11);

      // 6: one-cycle reset mid-RUN
      rst = 1'b0;
      tick();
      rst = 1'b1;
      chk("t6_str", {str_rd, str_wr}, '0);
      chk("t6_misc", {stats, active, clear}, 4'b0000);
      tick();
      chk("t6_idle", {active, str_rd.valid, str_wr.valid}, 3'b000);
      ctrl.go = 1'b1;
      tick();
      chk("t6_restart", {clear, active}, 2'b11);
      ctrl.go = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
